// File: rtl/class_arb_pkg.sv
// Shared definitions for the two-class weighted arbiter: FSM state encoding,
// default word width and the turn-counter width helper.
package class_arb_pkg;

  localparam int unsigned DATA_SIZE_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE0 = 2'd1,
    ST_SERVE1 = 2'd2
  } state_e;

  // Bits needed to hold a turn count of up to max(w0, w1).
  function automatic int unsigned cnt_width(input int unsigned w0, input int unsigned w1);
    int unsigned wmax;
    wmax = (w0 > w1) ? w0 : w1;
    return $clog2(wmax + 1);
  endfunction

endpackage

// File: rtl/class_arb_if.sv
// FIFO-side and downstream-side signals of the class arbiter.
// master = arbiter, slave = surrounding FIFOs / sink.
interface class_arb_if #(
  parameter int unsigned DATA_SIZE = class_arb_pkg::DATA_SIZE_DEF
) ();

  logic                 fifo0_empty;
  logic                 fifo1_empty;
  logic [DATA_SIZE-1:0] fifo0_data;
  logic [DATA_SIZE-1:0] fifo1_data;
  logic                 down_af;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 class_out;

  modport master (
    input  fifo0_empty, fifo1_empty, fifo0_data, fifo1_data, down_af,
    output pop0, pop1, data_out, valid_out, class_out
  );

  modport slave (
    output fifo0_empty, fifo1_empty, fifo0_data, fifo1_data, down_af,
    input  pop0, pop1, data_out, valid_out, class_out
  );

endinterface

// File: rtl/class_arb_cnt.sv
// Per-turn pop counter with terminal-count compare against the weight limit
// of the class currently being served.
module class_arb_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + WIDTH'(1);
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/class_arbiter.sv
// Weighted round-robin arbiter between two class FIFOs: up to W0 pops from
// class 0 then up to W1 from class 1, stalled by downstream almost-full.
// Popped words appear one cycle later on data_out with class_out tagging them.
module class_arbiter
  import class_arb_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned W0        = 3,
  parameter int unsigned W1        = 1
) (
  input logic         clk,
  input logic         reset,
  class_arb_if.master bus
);

  localparam int unsigned     CW   = cnt_width(W0, W1);
  localparam logic [CW-1:0]   LIM0 = CW'(W0 - 1);
  localparam logic [CW-1:0]   LIM1 = CW'(W1 - 1);

  state_e               state_q;
  logic                 last_q;
  logic                 pop0, pop1;
  logic                 cur_empty, turn_end;
  logic                 cnt_inc, cnt_clr, cnt_tc;
  logic [CW-1:0]        cnt_limit, cnt;
  logic                 valid_q, class_q;
  logic [DATA_SIZE-1:0] hold_q, rd_data;

  assign pop0 = (state_q == ST_SERVE0) & ~bus.fifo0_empty & ~bus.down_af;
  assign pop1 = (state_q == ST_SERVE1) & ~bus.fifo1_empty & ~bus.down_af;

  // A turn ends when the served FIFO runs dry or the weight-limited pop happens.
  assign cur_empty = (state_q == ST_SERVE1) ? bus.fifo1_empty : bus.fifo0_empty;
  assign turn_end  = cur_empty | cnt_tc;
  assign cnt_limit = (state_q == ST_SERVE1) ? LIM1 : LIM0;
  assign cnt_inc   = (pop0 | pop1) & ~cnt_tc;
  assign cnt_clr   = ~bus.down_af & ((state_q == ST_IDLE) | turn_end);

  class_arb_cnt #(.WIDTH(CW)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (cnt_inc),
    .clr_i   (cnt_clr),
    .limit_i (cnt_limit),
    .cnt_o   (cnt),
    .tc_o    (cnt_tc)
  );

  // Arbitration FSM and last-served pointer; everything frozen under down_af.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else if (!bus.down_af) begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.fifo0_empty && (last_q || bus.fifo1_empty)) state_q <= ST_SERVE0;
          else if (!bus.fifo1_empty)                           state_q <= ST_SERVE1;
        end
        // On turn end: hand over if the other class waits, else keep serving
        // a new turn if this FIFO still had data, else go idle.
        ST_SERVE0: begin
          if (turn_end) begin
            last_q <= 1'b0;
            if (!bus.fifo1_empty)     state_q <= ST_SERVE1;
            else if (bus.fifo0_empty) state_q <= ST_IDLE;
          end
        end
        ST_SERVE1: begin
          if (turn_end) begin
            last_q <= 1'b1;
            if (!bus.fifo0_empty)     state_q <= ST_SERVE0;
            else if (bus.fifo1_empty) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data = class_q ? bus.fifo1_data : bus.fifo0_data;

  // Output qualifiers track last cycle's pop; hold register keeps the last delivered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      class_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= pop0 | pop1;
      class_q <= pop1;
      if (valid_q) hold_q <= rd_data;
    end
  end

  assign bus.pop0      = pop0;
  assign bus.pop1      = pop1;
  assign bus.valid_out = valid_q;
  assign bus.class_out = class_q;
  assign bus.data_out  = valid_q ? rd_data : hold_q;

endmodule

// File: doc/class_arbiter.md
CLASS_ARBITER -- requirements
Module: class_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 10, width of a class-switched word.
REQ-002 Parameter W0, default 3, maximum consecutive pops from class-0 FIFO per turn.
REQ-003 Parameter W1, default 1, maximum consecutive pops from class-1 FIFO per turn.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fifo0_empty  input  1  class-0 FIFO empty flag.
REQ-007 fifo1_empty  input  1  class-1 FIFO empty flag.
REQ-008 fifo0_data  input  DATA_SIZE  class-0 FIFO read data, valid the cycle after pop0.
REQ-009 fifo1_data  input  DATA_SIZE  class-1 FIFO read data, valid the cycle after pop1.
REQ-010 down_af  input  1  downstream almost-full; stalls arbitration.
REQ-011 pop0  output  1  read strobe to class-0 FIFO.
REQ-012 pop1  output  1  read strobe to class-1 FIFO.
REQ-013 data_out  output  DATA_SIZE  arbitrated word.
REQ-014 valid_out  output  1  data_out qualifier.
REQ-015 class_out  output  1  class of word on data_out (0 or 1).

Function
REQ-016 FSM states IDLE, SERVE0, SERVE1; registered last-served pointer `last` and turn counter `cnt` (width ceil(log2(max(W0,W1)+1))).
REQ-017 pop0 = (state==SERVE0) & ~fifo0_empty & ~down_af; pop1 = (state==SERVE1) & ~fifo1_empty & ~down_af; pop0 and pop1 never both 1.
REQ-018 IDLE: no pops; next SERVE0 if ~fifo0_empty & (last==1 | fifo1_empty); else SERVE1 if ~fifo1_empty; else IDLE; cnt cleared on leaving IDLE.
REQ-019 SERVEx: each pop increments cnt; on the pop where cnt==Wx-1, set last=x, clear cnt, go SERVEy if FIFO y non-empty, else stay SERVEx (new turn) if FIFO x non-empty, else IDLE.
REQ-020 SERVEx with FIFO x empty and no down_af: set last=x, clear cnt, go SERVEy if FIFO y non-empty, else IDLE.
REQ-021 down_af=1: state, cnt, last frozen; no pops; in-flight word from previous cycle's pop still delivered.
REQ-022 valid_out registered: valid_out = pop0|pop1 of previous cycle; class_out registered = pop1 of previous cycle.
REQ-023 data_out = class_out ? fifo1_data : fifo0_data when valid_out=1; holds last delivered value when valid_out=0.
REQ-024 Pop-to-output latency exactly 1 cycle; sustained throughput 1 word/cycle while any FIFO non-empty and down_af=0, except one bubble on IDLE exit.
REQ-025 Word order within a class preserved; steady-state share with both FIFOs backlogged is W0:W1.

Reset
REQ-026 While reset=1: state=IDLE, last=1, cnt=0, pop0=pop1=0, valid_out=0, class_out=0, data_out=0.
REQ-027 Reset asserted mid-turn discards in-flight word (valid_out=0 next cycle); first grant after release goes to class 0 if non-empty.

Structure
REQ-028 Shared package class_arb_pkg holds state encoding constants and DATA_SIZE default.
REQ-029 Turn counter with terminal-count compare is sub-module class_arb_cnt; FSM, pop logic and output register remain in class_arbiter.

Verification
REQ-030 Reset then FIFO0 holds 0x011,0x012, FIFO1 empty -> pop0 cycles 2,3 after IDLE exit; data_out 0x011,0x012 with class_out=0, then IDLE.
REQ-031 Both FIFOs backlogged, W0=3, W1=1 -> class_out pattern 0,0,0,1 repeating, no bubbles after first word.
REQ-032 down_af raised after second class-0 pop for 4 cycles -> no pops for 4 cycles, one trailing valid word, then third class-0 pop resumes turn.
REQ-033 FIFO0 empties after 1 pop of its turn, FIFO1 non-empty -> immediate switch to SERVE1, no idle cycle.
REQ-034 Reset asserted while valid_out=1 with pop1 active -> all outputs 0 next edge; after release with both non-empty, first pop is pop0.
REQ-035 Behavioural and synthesized netlists driven in lockstep -> pop0, pop1, valid_out, class_out, data_out identical every cycle.
